// File: rtl/motion_input_ctrl.sv
// Four push-buttons -> synchronised, debounced levels -> per-axis auto-repeat
// pulses, arbitrated so rotate and move never pulse in the same cycle.
module motion_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIRST_DELAY     = 6250000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fwd,
    input  logic       btn_back,
    output logic [1:0] rotate,
    output logic [1:0] move,
    output logic [3:0] btn_state
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Bit order matches btn_state: {left, right, fwd, back}
    logic [3:0] btn_raw;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] btn_db;

    assign btn_raw = {btn_left, btn_right, btn_fwd, btn_back};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             lvl_q, lvl_d;

            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                if (sync2_q[gi] != lvl_q) begin
                    if (cnt_q == DEB_LAST) begin
                        lvl_d = ~lvl_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign btn_db[gi] = lvl_q;
        end
    endgenerate

    assign btn_state = btn_db;

    // Axis requests packed as {move, rotate}; opposing buttons cancel to 00
    logic [3:0] axis_req;
    logic [3:0] axis_pulse;

    assign axis_req[1:0] = (btn_db[2] & ~btn_db[3]) ? 2'b01 :
                           (btn_db[3] & ~btn_db[2]) ? 2'b10 : 2'b00;
    assign axis_req[3:2] = (btn_db[0] & ~btn_db[1]) ? 2'b01 :
                           (btn_db[1] & ~btn_db[0]) ? 2'b10 : 2'b00;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            rpt_state_e       state_q, state_d;
            logic [1:0]       dir_q, dir_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [1:0]       req;
            logic [1:0]       pulse;

            assign req = axis_req[2*gi +: 2];

            always_comb begin
                state_d = state_q;
                dir_d   = dir_q;
                cnt_d   = cnt_q;
                pulse   = 2'b00;
                case (state_q)
                    ST_IDLE: begin
                        if (req != 2'b00) begin
                            dir_d   = req;
                            pulse   = req;
                            cnt_d   = '0;
                            state_d = ST_FIRST;
                        end
                    end
                    ST_FIRST: begin
                        if (req != dir_q) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else if (cnt_q == FIRST_LAST) begin
                            pulse   = dir_q;
                            cnt_d   = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (req != dir_q) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else if (cnt_q == REP_LAST) begin
                            pulse = dir_q;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    dir_q   <= 2'b00;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    dir_q   <= dir_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign axis_pulse[2*gi +: 2] = pulse;
        end
    endgenerate

    logic [1:0] pend_q, pend_d;
    logic [1:0] rotate_q, rotate_d;
    logic [1:0] move_q, move_d;
    logic [1:0] rot_cand;

    // Move wins a collision; the rotate pulse waits one cycle in pend_q and
    // leaves the rotate FSM's own schedule untouched.
    always_comb begin
        rot_cand = (pend_q != 2'b00) ? pend_q : axis_pulse[1:0];
        move_d   = axis_pulse[3:2];
        rotate_d = rot_cand;
        pend_d   = 2'b00;
        if ((axis_pulse[3:2] != 2'b00) && (rot_cand != 2'b00)) begin
            rotate_d = 2'b00;
            pend_d   = rot_cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 2'b00;
            rotate_q <= 2'b00;
            move_q   <= 2'b00;
        end else begin
            pend_q   <= pend_d;
            rotate_q <= rotate_d;
            move_q   <= move_d;
        end
    end

    assign rotate = rotate_q;
    assign move   = move_q;

endmodule

// File: tb/tb_motion_input_ctrl.sv
// Directed test-plan scenarios plus random button patterns, checked each cycle
// against an elapsed-time reference model of debounce, repeat and arbitration.
module tb_motion_input_ctrl;

    localparam int DEB = 4;
    localparam int FD  = 20;
    localparam int RP  = 8;
    localparam int CW  = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       bl = 1'b0, br = 1'b0, bf = 1'b0, bb = 1'b0;
    logic [1:0] rotate, move;
    logic [3:0] btn_state;

    motion_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .FIRST_DELAY    (FD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_left (bl),
        .btn_right(br),
        .btn_fwd  (bf),
        .btn_back (bb),
        .rotate   (rotate),
        .move     (move),
        .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model state (values after the most recent clock edge)
    logic [3:0] m_s1, m_s2, m_db;
    int         m_run [4];
    bit         m_active [2];
    logic [1:0] m_dir [2];
    int         m_age [2];
    logic [1:0] m_pend, m_rot, m_mov;

    int         rot_cyc [$];
    logic [1:0] rot_val [$];
    int         mov_cyc [$];
    logic [1:0] mov_val [$];

    function automatic logic [1:0] req_of(input logic pos, input logic neg);
        if (pos && !neg) return 2'b01;
        if (neg && !pos) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset;
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        for (int a = 0; a < 2; a++) begin
            m_active[a] = 1'b0; m_dir[a] = 2'b00; m_age[a] = 0;
        end
        m_pend = 2'b00; m_rot = 2'b00; m_mov = 2'b00;
    endtask

    task automatic model_step;
        logic [1:0] rq [2];
        logic [1:0] pl [2];
        rq[0] = req_of(m_db[2], m_db[3]);
        rq[1] = req_of(m_db[0], m_db[1]);
        for (int a = 0; a < 2; a++) begin
            pl[a] = 2'b00;
            if (rq[a] == 2'b00) begin
                m_active[a] = 1'b0;
            end else if (!m_active[a]) begin
                m_active[a] = 1'b1;
                m_dir[a]    = rq[a];
                m_age[a]    = 0;
                pl[a]       = rq[a];
            end else if (rq[a] != m_dir[a]) begin
                m_active[a] = 1'b0;
            end else begin
                m_age[a]++;
                if (m_age[a] == FD || (m_age[a] > FD && (m_age[a] - FD) % RP == 0))
                    pl[a] = m_dir[a];
            end
        end
        m_mov = pl[1];
        if (m_pend != 2'b00) begin
            m_rot  = m_pend;
            m_pend = 2'b00;
        end else if (pl[0] != 2'b00 && pl[1] != 2'b00) begin
            m_rot  = 2'b00;
            m_pend = pl[0];
        end else begin
            m_rot = pl[0];
        end
        for (int b = 0; b < 4; b++) begin
            if (m_s2[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_db[b]  = ~m_db[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = {bl, br, bf, bb};
    endtask

    task automatic tick;
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        cyc++;
        @(negedge clk);
        check_eq("rotate", rotate, m_rot);
        check_eq("move", move, m_mov);
        check_eq("btn_state", btn_state, m_db);
        if (rotate != 2'b00) begin
            rot_cyc.push_back(cyc);
            rot_val.push_back(rotate);
            $display("cyc=%0d rotate=%b", cyc, rotate);
        end
        if (move != 2'b00) begin
            mov_cyc.push_back(cyc);
            mov_val.push_back(move);
            $display("cyc=%0d move=%b", cyc, move);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic set_btn(input logic [3:0] v);
        {bl, br, bf, bb} = v;
    endtask

    task automatic clear_logs;
        rot_cyc.delete(); rot_val.delete();
        mov_cyc.delete(); mov_val.delete();
    endtask

    function automatic logic [1:0] rot_at(input int c);
        foreach (rot_cyc[i]) if (rot_cyc[i] == c) return rot_val[i];
        return 2'b00;
    endfunction

    function automatic logic [1:0] mov_at(input int c);
        foreach (mov_cyc[i]) if (mov_cyc[i] == c) return mov_val[i];
        return 2'b00;
    endfunction

    function automatic int rot_count(input int lo, input int hi);
        int n = 0;
        foreach (rot_cyc[i]) if (rot_cyc[i] > lo && rot_cyc[i] <= hi) n++;
        return n;
    endfunction

    int c0;
    int rep_offs [6] = '{0, 20, 28, 36, 44, 52};

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        wait_cycles(3);
        check_eq("reset_rotate", rotate, 0);
        check_eq("reset_state", btn_state, 0);
        rst_n = 1'b1;
        wait_cycles(5);

        // Glitch of DEB-1 cycles is rejected
        clear_logs(); c0 = cyc;
        set_btn(4'b1000); wait_cycles(3);
        set_btn(4'b0000); wait_cycles(15);
        check_eq("glitch_pulses", rot_cyc.size(), 0);
        check_eq("glitch_state", btn_state, 0);

        // Single press: one pulse DEB+3 cycles after the raw edge
        clear_logs(); c0 = cyc;
        set_btn(4'b0100); wait_cycles(10);
        set_btn(4'b0000); wait_cycles(15);
        check_eq("single_count", rot_cyc.size(), 1);
        if (rot_cyc.size() > 0) begin
            check_eq("single_latency", rot_cyc[0] - c0, DEB + 3);
            check_eq("single_dir", rot_val[0], 2'b01);
        end

        // Auto-repeat schedule
        clear_logs(); c0 = cyc;
        set_btn(4'b0010); wait_cycles(60);
        set_btn(4'b0000); wait_cycles(20);
        check_eq("repeat_count", mov_cyc.size(), 6);
        if (mov_cyc.size() == 6) begin
            check_eq("repeat_first", mov_cyc[0] - c0, DEB + 3);
            for (int i = 0; i < 6; i++) begin
                check_eq("repeat_offset", mov_cyc[i] - mov_cyc[0], rep_offs[i]);
                check_eq("repeat_dir", mov_val[i], 2'b10);
            end
        end

        // Conflict: both rotate buttons stop pulses; releasing left re-serves right
        clear_logs(); c0 = cyc;
        set_btn(4'b1000); wait_cycles(30);
        set_btn(4'b1100); wait_cycles(30);
        set_btn(4'b0100); wait_cycles(20);
        set_btn(4'b0000); wait_cycles(15);
        check_eq("conflict_silent", rot_count(c0 + 36, c0 + 66), 0);
        check_eq("conflict_fresh", rot_at(c0 + 67), 2'b01);

        // Arbitration: move first, rotate deferred, left schedule unshifted
        clear_logs(); c0 = cyc;
        set_btn(4'b1001); wait_cycles(10);
        set_btn(4'b1000); wait_cycles(25);
        set_btn(4'b0000); wait_cycles(15);
        check_eq("arb_move", mov_at(c0 + 7), 2'b01);
        check_eq("arb_rot_held", rot_at(c0 + 7), 2'b00);
        check_eq("arb_rot_deferred", rot_at(c0 + 8), 2'b10);
        check_eq("arb_repeat", rot_at(c0 + 27), 2'b10);
        check_eq("arb_repeat_late", rot_at(c0 + 28), 2'b00);

        // Reset asserted mid-hold while a pulse is on the output
        clear_logs(); c0 = cyc;
        set_btn(4'b0100); wait_cycles(35);
        check_eq("pre_reset_pulse", rotate, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rotate", rotate, 0);
        check_eq("async_move", move, 0);
        check_eq("async_state", btn_state, 0);
        model_reset();
        wait_cycles(2);
        rst_n = 1'b1;
        clear_logs(); c0 = cyc;
        wait_cycles(15);
        check_eq("held_reset_count", (rot_cyc.size() > 0) ? 1 : 0, 1);
        if (rot_cyc.size() > 0) begin
            check_eq("held_reset_latency", rot_cyc[0] - c0, DEB + 3);
            check_eq("held_reset_dir", rot_val[0], 2'b01);
        end
        set_btn(4'b0000); wait_cycles(15);

        // Random button patterns against the model
        for (int s = 0; s < 40; s++) begin
            set_btn(4'($urandom_range(0, 15)));
            wait_cycles($urandom_range(1, 40));
        end
        set_btn(4'b0000); wait_cycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
